// File: rtl/twiddle_pass_scheduler_if.sv
// Handshake and control bundle between a twiddle-row requester and the pass scheduler.
interface twiddle_pass_scheduler_if;
    logic        start;
    logic [2:0]  row;
    logic        busy;
    logic        done;
    logic [23:0] Shuf_Ctrl;
    logic [23:0] Type_Sel;
    logic [23:0] Bypass_Sel;
    logic [23:0] DeShuf_Ctrl;
    logic [7:0]  Bypass_EN;
    logic [7:0]  Hold_Ctrl;
    logic [7:0]  DFF_Ctrl;

    modport master (
        output start, row,
        input  busy, done, Shuf_Ctrl, Type_Sel, Bypass_Sel, DeShuf_Ctrl,
               Bypass_EN, Hold_Ctrl, DFF_Ctrl
    );

    modport slave (
        input  start, row,
        output busy, done, Shuf_Ctrl, Type_Sel, Bypass_Sel, DeShuf_Ctrl,
               Bypass_EN, Hold_Ctrl, DFF_Ctrl
    );
endinterface

// File: rtl/twiddle_pass_scheduler.sv
// Schedules the 8 lanes of one twiddle row onto 8 shared multiplier blocks,
// granting conflict-free lanes per pass until every lane has been served.
module twiddle_pass_scheduler (
    input  logic                     clk,
    input  logic                     rst,
    twiddle_pass_scheduler_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, PASS, DONE} state_t;

    state_t      state, state_d;
    logic [2:0]  row_q, row_d;
    logic [7:0]  pend, pend_d;

    logic        busy_d, done_d;
    logic [7:0]  hold_d, byp_en_d;
    logic [23:0] shuf_d, type_d, byp_sel_d, deshuf_d;

    logic        busy_r, done_r;
    logic [7:0]  hold_r, byp_en_r;
    logic [23:0] shuf_r, type_r, byp_sel_r, deshuf_r;

    // Octant-folded base: 0 means trivial rotation, 1..8 selects a multiplier block.
    function automatic logic [3:0] lane_base(input logic [2:0] r, input logic [2:0] k);
        logic [5:0] e;
        e = 6'(r) * 6'(k);
        return e[3] ? (4'd8 - {1'b0, e[2:0]}) : {1'b0, e[2:0]};
    endfunction

    function automatic logic [2:0] lane_oct(input logic [2:0] r, input logic [2:0] k);
        logic [5:0] e;
        e = 6'(r) * 6'(k);
        return e[5:3];
    endfunction

    // Trivial lanes always go; each block takes its lowest-index pending lane.
    function automatic logic [7:0] grant_mask(input logic [2:0] r, input logic [7:0] p);
        logic [7:0] g;
        logic [8:0] taken;
        logic [3:0] b;
        g     = '0;
        taken = '0;
        for (int k = 0; k < 8; k++) begin
            b = lane_base(r, 3'(k));
            if (p[k]) begin
                if (b == 4'd0) begin
                    g[k] = 1'b1;
                end else if (!taken[b]) begin
                    g[k]     = 1'b1;
                    taken[b] = 1'b1;
                end
            end
        end
        return g;
    endfunction

    always_comb begin
        state_d = state;
        row_d   = row_q;
        pend_d  = pend;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_d = PASS;
                    row_d   = bus.row;
                    pend_d  = 8'hFF;
                end
            end
            PASS: begin
                pend_d  = pend & ~grant_mask(row_q, pend);
                state_d = (pend_d == 8'h00) ? DONE : PASS;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        logic [7:0] g;
        logic [3:0] b;
        logic [2:0] o;
        int         m;
        g         = '0;
        b         = '0;
        o         = '0;
        m         = 0;
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
        hold_d    = 8'hFF;
        byp_en_d  = '0;
        byp_sel_d = '0;
        shuf_d    = '0;
        type_d    = '0;
        deshuf_d  = '0;
        if (state_d == PASS) begin
            g = grant_mask(row_d, pend_d);
            for (int k = 0; k < 8; k++) begin
                if (g[k]) begin
                    b         = lane_base(row_d, 3'(k));
                    o         = lane_oct(row_d, 3'(k));
                    hold_d[k] = 1'b0;
                    if (b == 4'd0) begin
                        byp_en_d[k]          = 1'b1;
                        byp_sel_d[3*k +: 3]  = o;
                    end else begin
                        m                    = int'(b) - 1;
                        shuf_d[3*m +: 3]     = 3'(k);
                        type_d[3*m +: 3]     = o;
                        deshuf_d[3*k +: 3]   = 3'(m);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            row_q     <= '0;
            pend      <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            hold_r    <= 8'hFF;
            byp_en_r  <= '0;
            byp_sel_r <= '0;
            shuf_r    <= '0;
            type_r    <= '0;
            deshuf_r  <= '0;
        end else begin
            state     <= state_d;
            row_q     <= row_d;
            pend      <= pend_d;
            busy_r    <= busy_d;
            done_r    <= done_d;
            hold_r    <= hold_d;
            byp_en_r  <= byp_en_d;
            byp_sel_r <= byp_sel_d;
            shuf_r    <= shuf_d;
            type_r    <= type_d;
            deshuf_r  <= deshuf_d;
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.Hold_Ctrl   = hold_r;
    assign bus.Bypass_EN   = byp_en_r;
    assign bus.Bypass_Sel  = byp_sel_r;
    assign bus.Shuf_Ctrl   = shuf_r;
    assign bus.Type_Sel    = type_r;
    assign bus.DeShuf_Ctrl = deshuf_r;
    // Lane outputs always come from the holding registers.
    assign bus.DFF_Ctrl    = 8'hFF;

endmodule

// File: tb/tb_twiddle_pass_scheduler.sv
// Scoreboard bench: directed rows push hand-derived per-cycle output vectors; a negedge monitor checks them.
module tb_twiddle_pass_scheduler;

    typedef struct packed {
        logic        done;
        logic [7:0]  hold;
        logic [7:0]  byp_en;
        logic [23:0] byp_sel;
        logic [23:0] shuf;
        logic [23:0] typ;
        logic [23:0] deshuf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    exp_t cur;
    exp_t idle_pat;

    twiddle_pass_scheduler_if bus();

    twiddle_pass_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t snapshot();
        exp_t s;
        s.done    = bus.done;
        s.hold    = bus.Hold_Ctrl;
        s.byp_en  = bus.Bypass_EN;
        s.byp_sel = bus.Bypass_Sel;
        s.shuf    = bus.Shuf_Ctrl;
        s.typ     = bus.Type_Sel;
        s.deshuf  = bus.DeShuf_Ctrl;
        return s;
    endfunction

    task automatic check_vec(input string name, input exp_t got, input exp_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got done=%b hold=%h byp_en=%h byp_sel=%h shuf=%h type=%h deshuf=%h required done=%b hold=%h byp_en=%h byp_sel=%h shuf=%h type=%h deshuf=%h",
                     name, got.done, got.hold, got.byp_en, got.byp_sel, got.shuf, got.typ, got.deshuf,
                     exp.done, exp.hold, exp.byp_en, exp.byp_sel, exp.shuf, exp.typ, exp.deshuf);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", name, got, exp);
        end
    endtask

    task automatic exp_begin();
        cur      = '0;
        cur.hold = 8'hFF;
    endtask

    // m = 0 marks a trivial (bypass) lane; o is the octant for that lane.
    task automatic exp_lane(input int k, input int m, input int o);
        cur.hold[k] = 1'b0;
        if (m == 0) begin
            cur.byp_en[k]          = 1'b1;
            cur.byp_sel[3*k +: 3]  = 3'(o);
        end else begin
            cur.shuf[3*(m-1) +: 3] = 3'(k);
            cur.typ[3*(m-1) +: 3]  = 3'(o);
            cur.deshuf[3*k +: 3]   = 3'(m-1);
        end
    endtask

    task automatic exp_push();
        q.push_back(cur);
    endtask

    task automatic exp_done();
        exp_begin();
        cur.done = 1'b1;
        exp_push();
    endtask

    task automatic push_row(input int r);
        case (r)
            0: begin
                exp_begin();
                for (int k = 0; k < 8; k++) exp_lane(k, 0, 0);
                exp_push();
                exp_done();
            end
            1: begin
                exp_begin();
                exp_lane(0, 0, 0);
                for (int k = 1; k < 8; k++) exp_lane(k, k, 0);
                exp_push();
                exp_done();
            end
            2: begin
                exp_begin();
                exp_lane(0, 0, 0); exp_lane(1, 2, 0); exp_lane(2, 4, 0);
                exp_lane(3, 6, 0); exp_lane(4, 8, 1);
                exp_push();
                exp_begin();
                exp_lane(5, 6, 1); exp_lane(6, 4, 1); exp_lane(7, 2, 1);
                exp_push();
                exp_done();
            end
            3: begin
                exp_begin();
                exp_lane(0, 0, 0); exp_lane(1, 3, 0); exp_lane(2, 6, 0); exp_lane(3, 7, 1);
                exp_lane(4, 4, 1); exp_lane(5, 1, 1); exp_lane(6, 2, 2); exp_lane(7, 5, 2);
                exp_push();
                exp_done();
            end
            4: begin
                exp_begin();
                exp_lane(0, 0, 0); exp_lane(4, 0, 2); exp_lane(1, 4, 0); exp_lane(2, 8, 1);
                exp_push();
                exp_begin();
                exp_lane(3, 4, 1); exp_lane(6, 8, 3);
                exp_push();
                exp_begin();
                exp_lane(5, 4, 2);
                exp_push();
                exp_begin();
                exp_lane(7, 4, 3);
                exp_push();
                exp_done();
            end
            default: ;
        endcase
    endtask

    // Monitor: busy cycles consume scoreboard entries, idle cycles must show the idle pattern.
    always @(negedge clk) begin
        exp_t e;
        checks++;
        if (bus.DFF_Ctrl !== 8'hFF) begin
            errors++;
            $display("FAIL dff_ctrl got=%h required=ff", bus.DFF_Ctrl);
        end
        if (bus.busy === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_busy got busy=1 done=%b hold=%h required idle", bus.done, bus.Hold_Ctrl);
            end else begin
                e = q.pop_front();
                check_vec("pass_vec", snapshot(), e);
            end
        end else begin
            check_vec("idle_vec", snapshot(), idle_pat);
        end
    end

    // Starts row r at the next edge and returns the cycle index (1-based) where done appears.
    task automatic run_row(input logic [2:0] r, input int n, input bit repulse);
        int cyc;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.row   = r;
        @(posedge clk); #1;
        bus.start = repulse;
        bus.row   = repulse ? 3'd5 : 3'd0;
        check_int("busy_cycle1", int'(bus.busy), 1);
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        bus.start = 1'b0;
        bus.row   = 3'd0;
        check_int($sformatf("done_cycle_r%0d", r), cyc, n + 1);
        @(posedge clk); #1;
        check_int("busy_after_done", int'(bus.busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout got=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        idle_pat      = '0;
        idle_pat.hold = 8'hFF;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.row   = 3'd0;
        #12;
        check_vec("reset_vec", snapshot(), idle_pat);
        check_int("reset_busy", int'(bus.busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        push_row(1); run_row(3'd1, 1, 1'b0);
        push_row(2); run_row(3'd2, 2, 1'b0);
        push_row(4); run_row(3'd4, 4, 1'b0);
        push_row(0); run_row(3'd0, 1, 1'b0);
        push_row(2); run_row(3'd2, 2, 1'b1);

        // Abort r=4 in its second pass with an asynchronous reset.
        exp_begin();
        exp_lane(0, 0, 0); exp_lane(4, 0, 2); exp_lane(1, 4, 0); exp_lane(2, 8, 1);
        exp_push();
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.row   = 3'd4;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.row   = 3'd0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_vec("async_reset_vec", snapshot(), idle_pat);
        check_int("async_reset_busy", int'(bus.busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check_int("no_done_after_abort", q.size(), 0);

        push_row(3); run_row(3'd3, 1, 1'b0);

        guard = 0;
        while (q.size() != 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        repeat (2) @(posedge clk);
        check_int("scoreboard_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
